// File: rtl/rr_stream_mux_pkg.sv
// Shared types and constants for the round-robin 2:1 stream mux.
package rr_stream_mux_pkg;

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_stream_mux_2to1_arb.sv
// Combinational two-requester arbiter: a lone requester always wins,
// a tie is broken by the priority pointer.
module rr_arbiter_2
   import rr_stream_mux_pkg::*;
(
   input  logic [1:0] req,
   input  pri_t       pri,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   // Grant decode: one-hot-or-zero grant plus the index of the winner
   always_comb begin
      gnt     = 2'b00;
      gnt_idx = SRC_A;
      case (req)
         2'b01: begin
            gnt     = 2'b01;
            gnt_idx = SRC_A;
         end
         2'b10: begin
            gnt     = 2'b10;
            gnt_idx = SRC_B;
         end
         2'b11: begin
            if (pri == PRI_A) begin
               gnt     = 2'b01;
               gnt_idx = SRC_A;
            end else begin
               gnt     = 2'b10;
               gnt_idx = SRC_B;
            end
         end
         default: begin
            gnt     = 2'b00;
            gnt_idx = SRC_A;
         end
      endcase
   end

endmodule

// File: rtl/rr_stream_mux_2to1.sv
// Two-input valid/ready stream selector with one registered output stage
// and a round-robin priority pointer that moves only on real transfers.
module rr_stream_mux_2to1
   import rr_stream_mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [WIDTH-1:0] b_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src
);

   pri_t             pri_r;
   logic             load_en_s;
   logic [1:0]       gnt_s;
   logic             gnt_idx_s;
   logic [WIDTH-1:0] sel_data_s;

   rr_arbiter_2 u_arb (
      .req     ({b_valid, a_valid}),
      .pri     (pri_r),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // The stage can take a word when empty or when its word leaves this cycle
   assign load_en_s = !out_valid || out_ready;
   assign a_ready   = load_en_s && gnt_s[0];
   assign b_ready   = load_en_s && gnt_s[1];

   // Data select follows the arbiter's winner
   always_comb begin
      sel_data_s = a_data;
      if (gnt_idx_s == SRC_B) begin
         sel_data_s = b_data;
      end else begin
         sel_data_s = a_data;
      end
   end

   // Output register: load the winner, empty on a grant-less load slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= {WIDTH{1'b0}};
         out_src   <= SRC_A;
      end else if (load_en_s) begin
         if (gnt_s != 2'b00) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_s;
            out_src   <= gnt_idx_s;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Priority FSM: hand priority to the other input after each transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri_r <= PRI_A;
      end else if (load_en_s && gnt_s[0]) begin
         pri_r <= PRI_B;
      end else if (load_en_s && gnt_s[1]) begin
         pri_r <= PRI_A;
      end else begin
         pri_r <= pri_r;
      end
   end

endmodule

// File: tb/tb_rr_stream_mux_2to1.sv
// Self-checking bench for rr_stream_mux_2to1: directed vector table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_rr_stream_mux_2to1;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, out_ready;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready, out_valid, out_src;
   logic [7:0] out_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic       ordy;
      logic       eov;
      logic [7:0] eod;
      logic       esrc;
      logic       ear;
      logic       ebr;
   } vec_t;

   vec_t vecs[15];

   rr_stream_mux_2to1 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_data    (b_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                        input logic [7:0] bd, input logic ordy);
      a_valid   = av;
      a_data    = ad;
      b_valid   = bv;
      b_data    = bd;
      out_ready = ordy;
   endtask

   // independent reference state for the random phase
   logic       m_ov, m_src, m_pri, ga, gb, ld;
   logic [7:0] m_data;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] exp_w;
   int         nout;

   initial begin
      vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 8'hA2, 1'b1, 8'hB1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'hA2, 1'b1, 8'hB1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_data", {24'd0, out_data}, 32'd0);
      chk("reset out_src", {31'd0, out_src}, 32'd0);
      rst = 1'b0;

      // directed table
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
         #1;
         chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].eov});
         chk($sformatf("vec%0d out_data", i), {24'd0, out_data}, {24'd0, vecs[i].eod});
         chk($sformatf("vec%0d out_src", i), {31'd0, out_src}, {31'd0, vecs[i].esrc});
         chk($sformatf("vec%0d a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ear});
         chk($sformatf("vec%0d b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].ebr});
      end

      // asynchronous reset while a word is held
      @(negedge clk);
      drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      #1;
      chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
      chk("pre-rst out_data", {24'd0, out_data}, 32'h5A);
      #1 rst = 1'b1;
      #1;
      chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("async rst out_data", {24'd0, out_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b1);
      #1;
      chk("post-rst first grant a_ready", {31'd0, a_ready}, 32'd1);
      chk("post-rst first grant b_ready", {31'd0, b_ready}, 32'd0);

      // B-only burst of 8 words at full rate
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
         #1;
         chk($sformatf("burst%0d b_ready", i), {31'd0, b_ready}, 32'd1);
         if (i > 1) begin
            chk($sformatf("burst%0d out_data", i), {24'd0, out_data}, i - 1);
            chk($sformatf("burst%0d out_src", i), {31'd0, out_src}, 32'd1);
         end
      end
      @(negedge clk);
      drive(1'b1, 8'hE0, 1'b1, 8'hE1, 1'b0);
      #1;
      chk("burst last out_data", {24'd0, out_data}, 32'd8);
      chk("burst last out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      #1;
      chk("pointer back at A a_ready", {31'd0, a_ready}, 32'd1);
      chk("pointer back at A b_ready", {31'd0, b_ready}, 32'd0);

      // randomized run against a reference model and per-source scoreboard
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      #2 rst = 1'b0;
      m_ov = 1'b0; m_data = 8'h00; m_src = 1'b0; m_pri = 1'b0; nout = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               8'($urandom), 1'($urandom_range(0, 3) != 0));
         #1;
         ld = !m_ov || out_ready;
         ga = a_valid && (!b_valid || !m_pri);
         gb = b_valid && (!a_valid || m_pri);
         chk("rand a_ready", {31'd0, a_ready}, {31'd0, ld && ga});
         chk("rand b_ready", {31'd0, b_ready}, {31'd0, ld && gb});
         chk("rand out_valid", {31'd0, out_valid}, {31'd0, m_ov});
         if (m_ov) begin
            chk("rand out_data", {24'd0, out_data}, {24'd0, m_data});
            chk("rand out_src", {31'd0, out_src}, {31'd0, m_src});
         end
         if (out_valid && out_ready) begin
            nout++;
            if (out_src ? (qb.size() == 0) : (qa.size() == 0)) begin
               chk("scoreboard underflow", 32'd1, 32'd0);
            end else begin
               exp_w = out_src ? qb.pop_front() : qa.pop_front();
               chk("scoreboard order", {24'd0, out_data}, {24'd0, exp_w});
            end
         end
         if (a_valid && a_ready) qa.push_back(a_data);
         if (b_valid && b_ready) qb.push_back(b_data);
         if (ld) begin
            if (ga) begin
               m_ov = 1'b1; m_data = a_data; m_src = 1'b0; m_pri = 1'b1;
            end else if (gb) begin
               m_ov = 1'b1; m_data = b_data; m_src = 1'b1; m_pri = 1'b0;
            end else begin
               m_ov = 1'b0;
            end
         end
      end
      // drain and confirm nothing was lost
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      #1;
      if (out_valid) begin
         exp_w = out_src ? qb.pop_front() : qa.pop_front();
         chk("drain word", {24'd0, out_data}, {24'd0, exp_w});
      end
      chk("scoreboard empty", qa.size() + qb.size(), 32'd0);
      chk("random outputs seen", {31'd0, nout > 500}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
